seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a DIGITS-position common-bus seven-segment display. It holds a double-buffered hex value and steps through the digit positions at a programmable refresh rate. A single instance of the team's hex-to-seven-segment decoder is shared across all positions, fed one nibble per slot. The block sits between the register/host logic that produces display values and the board-level segment and digit-select pins.

---
 rtl/seg_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered hex value.
// A single shared hex decoder is fed the nibble of the currently scanned position.

module seg_scan_hex7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);
    // Segment order a..g, bit 6 = a.
    always_comb begin
        seg_c = 7'b0000000;
        case (nibble)
            4'h0: seg_c = 7'b1111110;
            4'h1: seg_c = 7'b0110000;
            4'h2: seg_c = 7'b1101101;
            4'h3: seg_c = 7'b1111001;
            4'h4: seg_c = 7'b0110011;
            4'h5: seg_c = 7'b1011011;
            4'h6: seg_c = 7'b1011111;
            4'h7: seg_c = 7'b1110000;
            4'h8: seg_c = 7'b1111111;
            4'h9: seg_c = 7'b1111011;
            4'hA: seg_c = 7'b1110111;
            4'hB: seg_c = 7'b0011111;
            4'hC: seg_c = 7'b1001110;
            4'hD: seg_c = 7'b0111101;
            4'hE: seg_c = 7'b1001111;
            4'hF: seg_c = 7'b1000111;
            default: seg_c = 7'b0000000;
        endcase
    end
endmodule

module seg_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000,
    parameter int unsigned GUARD  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic [DIGITS-1:0]     Blank,
    input  logic                  LzSup,
    output logic                  Ready,
    output logic                  Frame,
    output logic [DIGITS-1:0]     Dig,
    output logic [6:0]            Seg
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned VW = 4 * DIGITS;

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [VW-1:0]     active;
    logic [VW-1:0]     shadow;
    logic              tick_c;
    logic              wrap_c;
    logic [3:0]        nib_c;
    logic [6:0]        glyph_c;
    logic [DIGITS-1:0] zero_from_c;
    logic [DIGITS-1:0] lit_c;
    logic [DIGITS-1:0] show_c;

    assign tick_c = (cnt == CW'(DIV - 1));
    assign wrap_c = tick_c && (idx == IW'(DIGITS - 1));

    // Slot prescaler and scan index.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick_c) begin
            cnt <= '0;
            idx <= wrap_c ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Double buffer: a load coinciding with the frame boundary bypasses the shadow.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            active <= '0;
            shadow <= '0;
            Ready  <= 1'b1;
        end else if (Load && wrap_c) begin
            active <= Value;
            shadow <= Value;
            Ready  <= 1'b1;
        end else if (Load) begin
            shadow <= Value;
            Ready  <= 1'b0;
        end else if (wrap_c && !Ready) begin
            active <= shadow;
            Ready  <= 1'b1;
        end
    end

    always_comb begin
        nib_c = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) nib_c = active[4*i +: 4];
        end
    end

    seg_scan_hex7 u_dec (
        .nibble (nib_c),
        .seg_c  (glyph_c)
    );

    // zero_from_c[p]: nibbles p..DIGITS-1 of active are all zero.
    always_comb begin
        logic z;
        z           = 1'b1;
        zero_from_c = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z              = z && (active[4*i +: 4] == 4'h0);
            zero_from_c[i] = z;
        end
    end

    always_comb begin
        lit_c = '0;
        for (int i = 0; i < DIGITS; i++) begin
            lit_c[i] = (idx == IW'(i)) && !Blank[i]
                       && !(LzSup && (i != 0) && zero_from_c[i]);
        end
        show_c = (cnt >= CW'(GUARD)) ? lit_c : '0;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Dig   <= '0;
            Seg   <= '0;
            Frame <= 1'b0;
        end else begin
            Dig   <= show_c;
            Seg   <= (|show_c) ? glyph_c : 7'b0000000;
            Frame <= wrap_c;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, DIV=8, GUARD=2.
module tb_seg_scan_ctrl;
    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001, S5 = 7'b1011011, S7 = 7'b1110000;
    localparam logic [6:0] SA = 7'b1110111, SB = 7'b0011111, SC = 7'b1001110;
    localparam logic [6:0] SE = 7'b1001111, SF = 7'b1000111, SX = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        lzsup;
    logic        ready;
    logic        frame;
    logic [3:0]  dig;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      blank;
        logic            lz;
        logic [3:0][3:0] dig;
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t vecs [6];

    seg_scan_ctrl #(.DIGITS(4), .DIV(8), .GUARD(2)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .Load  (load),
        .Value (value),
        .Blank (blank),
        .LzSup (lzsup),
        .Ready (ready),
        .Frame (frame),
        .Dig   (dig),
        .Seg   (seg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Steps until Frame is seen; reports whether pattern pat appeared on Seg meanwhile.
    task automatic wait_frame(input logic [6:0] pat, output logic seen);
        logic got;
        got  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (seg == pat) seen = 1'b1;
            if (frame) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no Frame expected Frame within 100 cycles");
        end
    endtask

    initial begin
        logic seen;
        int   n;

        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {4'b1000, 4'b0100, 4'b0010, 4'b0001}, {S1, S2, SA, SF}};
        vecs[1] = '{16'h0005, 4'b0000, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0001}, {SX, SX, SX, S5}};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0001}, {SX, SX, SX, S0}};
        vecs[3] = '{16'h0B00, 4'b0100, 1'b0, {4'b1000, 4'b0000, 4'b0010, 4'b0001}, {S0, SX, S0, S0}};
        vecs[4] = '{16'h0B00, 4'b0100, 1'b1, {4'b0000, 4'b0000, 4'b0010, 4'b0001}, {SX, SX, S0, S0}};
        vecs[5] = '{16'h3C7E, 4'b0000, 1'b1, {4'b1000, 4'b0100, 4'b0010, 4'b0001}, {S3, SC, S7, SE}};

        rst = 1'b1; load = 1'b0; value = '0; blank = '0; lzsup = 1'b0;
        step(2);
        chk("rst_dig", 32'(dig), 32'h0);
        chk("rst_seg", 32'(seg), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_frame", 32'(frame), 32'h0);

        // Reset then idle.
        rst = 1'b0;
        step(1);
        chk("idle_c1_dig", 32'(dig), 32'h0);
        chk("idle_c1_seg", 32'(seg), 32'h0);
        step(1);
        chk("idle_c2_dig", 32'(dig), 32'h0);
        step(1);
        chk("idle_c3_dig", 32'(dig), 32'h1);
        chk("idle_c3_seg", 32'(seg), 32'(S0));
        n = 3;
        while (!frame && n < 100) begin
            step(1);
            n++;
        end
        chk("first_frame_cycle", 32'(n), 32'd32);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!frame && n < 100);
        chk("frame_period", 32'(n), 32'd32);
        chk("idle_ready", 32'(ready), 32'h1);

        // Two loads in one frame: only the later one is ever shown.
        step(2);
        load = 1'b1; value = 16'h1111;
        step(1);
        load = 1'b0;
        chk("two_ld_ready", 32'(ready), 32'h0);
        chk("two_ld_hold_seg", 32'(seg), 32'(S0));
        step(3);
        load = 1'b1; value = 16'h2222;
        step(1);
        load = 1'b0;
        wait_frame(S1, seen);
        chk("two_ld_never_1111", 32'(seen), 32'h0);
        chk("two_ld_ready_up", 32'(ready), 32'h1);
        step(5);
        chk("two_ld_dig0", 32'(dig), 32'h1);
        chk("two_ld_seg0", 32'(seg), 32'(S2));

        // Table: load mid-frame, check commit, then one full scan of slots.
        for (int v = 0; v < 6; v++) begin
            wait_frame(SX, seen);
            step(3);
            blank = vecs[v].blank;
            lzsup = vecs[v].lz;
            load  = 1'b1;
            value = vecs[v].value;
            step(1);
            load = 1'b0;
            chk($sformatf("v%0d_ready_fall", v), 32'(ready), 32'h0);
            wait_frame(SX, seen);
            chk($sformatf("v%0d_ready_rise", v), 32'(ready), 32'h1);
            step(5);
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("v%0d_slot%0d_dig", v, s), 32'(dig), 32'(vecs[v].dig[s]));
                chk($sformatf("v%0d_slot%0d_seg", v, s), 32'(seg), 32'(vecs[v].seg[s]));
                if (s < 3) step(8);
            end
        end

        // Blank takes effect one cycle later, mid-slot (active = 3C7E).
        wait_frame(SX, seen);
        step(4);
        chk("live_pre_dig", 32'(dig), 32'h1);
        blank = 4'b0001;
        step(1);
        chk("live_blank_dig", 32'(dig), 32'h0);
        chk("live_blank_seg", 32'(seg), 32'h0);
        blank = 4'b0000;
        step(1);
        chk("live_unblank_dig", 32'(dig), 32'h1);
        chk("live_unblank_seg", 32'(seg), 32'(SE));

        // Load exactly on the wrap tick commits in the same boundary.
        lzsup = 1'b0;
        wait_frame(SX, seen);
        step(31);
        load = 1'b1; value = 16'h0BEE;
        step(1);
        load = 1'b0;
        chk("wrap_ld_frame", 32'(frame), 32'h1);
        chk("wrap_ld_ready", 32'(ready), 32'h1);
        step(5);
        chk("wrap_ld_dig0", 32'(dig), 32'h1);
        chk("wrap_ld_seg0", 32'(seg), 32'(SE));
        step(16);
        chk("wrap_ld_dig2", 32'(dig), 32'h4);
        chk("wrap_ld_seg2", 32'(seg), 32'(SB));
        step(1);
        chk("wrap_ld_ready_hold", 32'(ready), 32'h1);

        // Reset with a pending value.
        wait_frame(SX, seen);
        step(4);
        chk("rp_pre_dig", 32'(dig), 32'h1);
        load = 1'b1; value = 16'h5555;
        step(1);
        load = 1'b0;
        chk("rp_pending", 32'(ready), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("rp_async_dig", 32'(dig), 32'h0);
        chk("rp_async_seg", 32'(seg), 32'h0);
        chk("rp_async_ready", 32'(ready), 32'h1);
        load = 1'b1; value = 16'h7777;
        step(2);
        load = 1'b0;
        rst  = 1'b0;
        step(1);
        chk("rp_ready_after", 32'(ready), 32'h1);
        wait_frame(S5, seen);
        chk("rp_5555_never", 32'(seen), 32'h0);
        step(5);
        chk("rp_active0_dig", 32'(dig), 32'h1);
        chk("rp_active0_seg", 32'(seg), 32'(S0));
        step(8);
        chk("rp_active0_seg1", 32'(seg), 32'(S0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
